// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Mode encoding and the shift-direction helper.
package shifter_pkg;

    typedef enum logic [2:0] {
        SLL  = 3'd0,
        SRL  = 3'd1,
        SRA  = 3'd2,
        ROL  = 3'd3,
        ROR  = 3'd4,
        PASS = 3'd5
    } shift_mode_t;

    function automatic logic is_right(input logic [2:0] mode);
        return (mode == SRL) || (mode == SRA) || (mode == ROR);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational level of the barrel shifter.
// Shifts or rotates by 2**K when i_amt_bit is set.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 0
) (
    input  logic [2**N-1:0] i_data,
    input  logic            i_amt_bit,
    input  logic [2:0]      i_mode,
    input  logic            i_sign,
    output logic [2**N-1:0] o_data
);

    localparam int W = 2**N;
    localparam int S = 2**K;

    logic [S-1:0] w_fill_r;
    logic [S-1:0] w_fill_l;
    logic [W-1:0] w_right;
    logic [W-1:0] w_left;
    logic         w_shift;

    always_comb begin
        w_fill_r = {S{i_sign & (i_mode == SRA)}};
        w_fill_l = '0;
        unique case (1'b1)
            (i_mode == ROR): w_fill_r = i_data[S-1:0];
            (i_mode == ROL): w_fill_l = i_data[W-1:W-S];
            default: ;
        endcase
        w_right = {w_fill_r, i_data[W-1:S]};
        w_left  = {i_data[W-S-1:0], w_fill_l};
        // Codes 5..7 all pass the operand through.
        w_shift = i_amt_bit && (i_mode < PASS);
        if (!w_shift)
            o_data = i_data;
        else if (is_right(i_mode))
            o_data = w_right;
        else
            o_data = w_left;
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Barrel shifter with one register stage per shift level
// and a single global advance enable (requires N >= 2).
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] a,
    input  logic [N-1:0]    amt,
    input  logic [2:0]      mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2**N-1:0] y
);

    localparam int W = 2**N;

    logic [W-1:0] r_data [N];
    logic [N-1:0] r_valid;
    logic [N-1:0] r_amt  [N-1];
    logic [2:0]   r_mode [N-1];
    logic [N-2:0] r_sign;

    logic [W-1:0] w_data_in  [N];
    logic [W-1:0] w_data_out [N];
    logic [N-1:0] w_amt_in   [N];
    logic [2:0]   w_mode_in  [N];
    logic         w_sign_in  [N];
    logic         w_en;

    assign w_en      = !r_valid[N-1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_valid[N-1];
    assign y         = r_data[N-1];

    for (genvar k = 0; k < N; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_data_in[k] = a;
            assign w_amt_in[k]  = amt;
            assign w_mode_in[k] = mode;
            assign w_sign_in[k] = a[W-1];
        end else begin : g_next
            assign w_data_in[k] = r_data[k-1];
            assign w_amt_in[k]  = r_amt[k-1];
            assign w_mode_in[k] = r_mode[k-1];
            assign w_sign_in[k] = r_sign[k-1];
        end

        shift_stage #(
            .N(N),
            .K(k)
        ) u_stage (
            .i_data   (w_data_in[k]),
            .i_amt_bit(w_amt_in[k][0]),
            .i_mode   (w_mode_in[k]),
            .i_sign   (w_sign_in[k]),
            .o_data   (w_data_out[k])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_sign  <= '0;
            for (int k = 0; k < N; k++)
                r_data[k] <= '0;
            for (int k = 0; k < N-1; k++) begin
                r_amt[k]  <= '0;
                r_mode[k] <= '0;
            end
        end else if (w_en) begin
            r_valid <= {r_valid[N-2:0], in_valid};
            // Stage 0 captures operands only on an accepted transfer.
            if (in_valid)
                r_data[0] <= w_data_out[0];
            for (int k = 1; k < N; k++)
                r_data[k] <= w_data_out[k];
            for (int k = 0; k < N-1; k++) begin
                if (k != 0 || in_valid) begin
                    r_amt[k]  <= w_amt_in[k] >> 1;
                    r_mode[k] <= w_mode_in[k];
                    r_sign[k] <= w_sign_in[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised scoreboard bench for the pipelined barrel shifter.
// Directed cases pin the reference model with literal results.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    localparam int N = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [N-1:0] amt = '0;
    logic [2:0]   mode = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] y;

    pipelined_barrel_shifter #(.N(N)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .amt      (amt),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y)
    );

    always #5 clk = ~clk;

    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           n_in = 0;
    int           n_out = 0;
    logic [W-1:0] exp_q[$];
    int           out_cyc[$];
    bit           rand_stall = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_y = '0;

    function automatic logic [W-1:0] model(input logic [W-1:0] av,
                                           input int sh, input int md);
        int x;
        int r;
        x = int'(av);
        case (md)
            0: r = x << sh;
            1: r = x >> sh;
            2: r = (x >= 128) ? ((x - 256) >>> sh) : (x >> sh);
            3: r = (x << sh) | (x >> (8 - sh));
            4: r = (x >> sh) | (x << (8 - sh));
            default: r = x;
        endcase
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 32'(out_valid), 1);
                check("stall_hold_y", 32'(y), 32'(prev_y));
            end
            if (out_valid && !out_ready)
                check("stall_in_ready", 32'(in_ready), 0);
            else
                check("in_ready", 32'(in_ready), 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected none", y);
                end else begin
                    check("result", 32'(y), 32'(exp_q.pop_front()));
                end
                out_cyc.push_back(cyc);
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, int'(amt), int'(mode)));
                n_in++;
            end
            prev_stall = out_valid && !out_ready;
            prev_y = y;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_stall)
            out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [W-1:0] av, input logic [N-1:0] sh,
                        input logic [2:0] md);
        int guard;
        bit acc;
        guard = 0;
        a = av;
        amt = sh;
        mode = md;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic run_one(input string name, input logic [W-1:0] av,
                           input logic [N-1:0] sh, input logic [2:0] md,
                           input logic [W-1:0] exp);
        int lat;
        check({"model_", name}, 32'(model(av, int'(sh), int'(md))), 32'(exp));
        a = av;
        amt = sh;
        mode = md;
        in_valid = 1'b1;
        @(negedge clk);
        check({"accept_", name}, 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom();
        amt = $urandom();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({"latency_", name}, 32'(lat), 3);
        check(name, 32'(y), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_y", 32'(y), 0);
        reset_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        run_one("sll", 8'h56, 3'd3, 3'd0, 8'hB0);
        run_one("srl", 8'h56, 3'd3, 3'd1, 8'h0A);
        run_one("sra", 8'hF0, 3'd1, 3'd2, 8'hF8);
        run_one("rol", 8'h75, 3'd4, 3'd3, 8'h57);
        run_one("ror", 8'hF8, 3'd2, 3'd4, 8'h3E);
        run_one("pass", 8'hA5, 3'd7, 3'd5, 8'hA5);
        run_one("amt0_sra", 8'h9C, 3'd0, 3'd2, 8'h9C);
        run_one("max_sra", 8'h80, 3'd7, 3'd2, 8'hFF);

        base = out_cyc.size();
        for (int i = 0; i < 8; i++)
            send($urandom(), $urandom(), 3'($urandom_range(0, 5)));
        drain();
        check("b2b_count", 32'(out_cyc.size() - base), 8);
        if (out_cyc.size() >= base + 8)
            check("b2b_consecutive", 32'(out_cyc[base+7] - out_cyc[base]), 7);

        for (int i = 0; i < 3; i++)
            send($urandom(), $urandom(), 3'($urandom_range(0, 5)));
        check("bp_full", 32'(out_valid), 1);
        out_ready = 1'b0;
        a = 8'h3C;
        amt = 3'd5;
        mode = 3'd3;
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'h3C, 3'd5, 3'd3);
        drain();
        check("bp_no_loss", 32'(n_out), 32'(n_in));

        for (int i = 0; i < 3; i++)
            send($urandom(), $urandom(), 3'($urandom_range(0, 5)));
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_y", 32'(y), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_in = 0;
        n_out = 0;
        run_one("post_rst", 8'h81, 3'd1, 3'd0, 8'h02);

        rand_stall = 1;
        for (int av = 0; av < 256; av++)
            for (int sh = 0; sh < 8; sh++)
                for (int md = 0; md < 6; md++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(8'(av), 3'(sh), 3'(md));
                end
        rand_stall = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            send($urandom(), $urandom(), 3'($urandom_range(5, 7)));
        drain();
        check("final_no_loss", 32'(n_out), 32'(n_in));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
